// File: rtl/alu_issue_buffer.sv
// ============================================================================
// Module   : alu_issue_buffer
// Purpose  : Reservation buffer that feeds the ALU issue stage. Dispatch
//            writes one micro-op per cycle into the lowest free entry. The
//            issue stage sees every entry in parallel and frees one entry
//            per cycle by index. A flush discards every pending entry.
// Ports    : CLK, RST (async, active-high)      - clock / reset
//            flush                              - discard all entries
//            alu_dispat_push / alu_dispat_info  - dispatch write
//            alu_buffer_full                    - all entries allocated
//            alu_buffer_pop / _pop_index        - issue-stage free
//            alu_buffer_malloc                  - per-entry valid bitmap
//            alu_issue_info                     - flat entry bus, entry i at [DW*i +: DW]
//            alu_buffer_cnt                     - allocated entry count
//            alu_buffer_stall_cnt, alu_buffer_hiwater
//                                               - only with ALU_BUFFER_PERF_EN
// Options  : define ALU_BUFFER_PERF_EN to add the refused-push counter and
//            the occupancy high-water mark.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ALU_ISSUE_INFO_DW
`define ALU_ISSUE_INFO_DW 32
`endif
`ifndef ALU_ISSUE_INFO_DP
`define ALU_ISSUE_INFO_DP 4
`endif

module alu_issue_buffer #(
    parameter int DW = `ALU_ISSUE_INFO_DW,
    parameter int DP = `ALU_ISSUE_INFO_DP
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush,
    input  logic                   alu_dispat_push,
    input  logic [DW-1:0]          alu_dispat_info,
    output logic                   alu_buffer_full,
    input  logic                   alu_buffer_pop,
    input  logic [$clog2(DP)-1:0]  alu_buffer_pop_index,
    output logic [DP-1:0]          alu_buffer_malloc,
    output logic [DW*DP-1:0]       alu_issue_info,
`ifdef ALU_BUFFER_PERF_EN
    output logic [31:0]            alu_buffer_stall_cnt,
    output logic [$clog2(DP):0]    alu_buffer_hiwater,
`endif
    output logic [$clog2(DP):0]    alu_buffer_cnt
);

    localparam int IW = $clog2(DP);
    localparam int CW = IW + 1;

    logic [DP-1:0] r_malloc;
    logic [CW-1:0] r_cnt;

    logic          w_full;
    logic          w_push_acc;
    logic          w_pop_acc;
    logic [IW-1:0] w_push_idx;
    logic [CW-1:0] w_cnt_nxt;

    assign w_full     = &r_malloc;
    assign w_push_acc = alu_dispat_push & ~w_full & ~flush;
    assign w_pop_acc  = alu_buffer_pop & r_malloc[alu_buffer_pop_index] & ~flush;

    // Lowest free slot of the pre-pop bitmap. Scanning downward lets the
    // lowest index overwrite any higher match. A slot freed by this cycle's
    // pop is therefore never reused in the same cycle.
    always_comb begin
        w_push_idx = '0;
        for (int i = DP - 1; i >= 0; i--) begin
            if (!r_malloc[i]) begin
                w_push_idx = IW'(i);
            end
        end
    end

    assign w_cnt_nxt = flush ? '0 : (r_cnt + CW'(w_push_acc) - CW'(w_pop_acc));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_malloc <= '0;
            r_cnt    <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (flush) begin
                r_malloc <= '0;
            end else begin
                // The push target is always free and the pop index is always
                // allocated, so these two writes never hit the same bit.
                if (w_push_acc) begin
                    r_malloc[w_push_idx] <= 1'b1;
                end
                if (w_pop_acc) begin
                    r_malloc[alu_buffer_pop_index] <= 1'b0;
                end
            end
        end
    end

    // Payload storage. A pop or a flush does not touch the payload, so an
    // entry stays stable up to and including the edge that pops it.
    for (genvar g = 0; g < DP; g++) begin : g_entry
        logic [DW-1:0] r_data;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_data <= '0;
            end else if (w_push_acc && (w_push_idx == IW'(g))) begin
                r_data <= alu_dispat_info;
            end
        end

        assign alu_issue_info[DW*g +: DW] = r_data;
    end

    assign alu_buffer_full   = w_full;
    assign alu_buffer_malloc = r_malloc;
    assign alu_buffer_cnt    = r_cnt;

`ifdef ALU_BUFFER_PERF_EN
    logic [31:0]   r_stall_cnt;
    logic [CW-1:0] r_hiwater;

    // The high-water mark tracks the next count, so it rises on the same
    // edge as alu_buffer_cnt. A flush does not clear either statistic.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_hiwater   <= '0;
        end else begin
            if (alu_dispat_push && w_full && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_cnt_nxt > r_hiwater) begin
                r_hiwater <= w_cnt_nxt;
            end
        end
    end

    assign alu_buffer_stall_cnt = r_stall_cnt;
    assign alu_buffer_hiwater   = r_hiwater;
`endif

`ifndef SYNTHESIS
    // The issue stage must only free entries that it saw as allocated.
    a_pop_allocated: assert property (@(posedge CLK) disable iff (RST)
        (alu_buffer_pop && !flush) |-> r_malloc[alu_buffer_pop_index]);

    a_cnt_matches_bitmap: assert property (@(posedge CLK) disable iff (RST)
        r_cnt == CW'($countones(r_malloc)));
`endif

endmodule

`default_nettype wire

// File: doc/alu_issue_buffer.md
Name: alu_issue_buffer

Overview:
- Reservation buffer feeding the ALU issue stage.
- Dispatch pushes one decoded ALU micro-op per cycle into the lowest-numbered free entry.
- The ALU issue stage sees every entry in parallel through the malloc bitmap and the flat info bus, then returns a pop strobe and index to free the issued entry.
- On flush all pending entries are discarded.

Parameters:
- DW, `ALU_ISSUE_INFO_DW, width of one issue-info entry.
- DP, `ALU_ISSUE_INFO_DP, entry count. Power of two, >= 2.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- flush  input  1  pipeline flush; discards all entries.
- alu_dispat_push  input  1  dispatch offers one entry this cycle.
- alu_dispat_info  input  DW  entry payload.
- alu_buffer_full  output  1  all DP entries allocated; a push is refused.
- alu_buffer_pop  input  1  issue stage frees an entry.
- alu_buffer_pop_index  input  $clog2(DP)  index of the entry to free.
- alu_buffer_malloc  output  DP  per-entry valid bitmap (registered).
- alu_issue_info  output  DW*DP  entry i occupies bits [DW*i +: DW] (registered).
- alu_buffer_cnt  output  $clog2(DP)+1  number of allocated entries (registered).

Behaviour:
- Reset (async, RST=1):
  - malloc = 0, every info entry = 0, cnt = 0.
  - full = 0, since it is derived from malloc.
  - Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Full: alu_buffer_full = &malloc, combinational from registered state.
- Push acceptance:
  - push_acc = alu_dispat_push & ~alu_buffer_full & ~flush.
  - Target slot = lowest index i with malloc[i]==0, computed from the current registered malloc.
  - On acceptance, at the next edge: malloc[target] <= 1 and info[target] <= alu_dispat_info.
- Pop acceptance:
  - pop_acc = alu_buffer_pop & malloc[alu_buffer_pop_index] & ~flush.
  - On acceptance, at the next edge: malloc[index] <= 0.
  - Info is left unchanged; its content is don't-care while malloc=0.
  - Popping an unallocated index changes no state and is flagged by a simulation-only assertion.
- Simultaneous push and pop, same cycle:
  - Both take effect.
  - The push target is chosen from pre-pop malloc, so a popped slot is never reused in the same cycle.
  - When the buffer is full, a simultaneous pop does not make room for that cycle's push: the push is refused and dispatch retries.
- Flush: at the next edge malloc <= 0 and cnt <= 0. Same-cycle push and pop are ignored. Info registers are untouched.
- Counter:
  - cnt <= cnt + push_acc - pop_acc.
  - It can never exceed DP or go below 0. An assertion checks cnt == popcount(malloc).
- Latency:
  - A pushed entry becomes visible on malloc/info one cycle after the push edge.
  - It may be popped in that same visible cycle.
- Pop data path: the issue stage samples alu_issue_info combinationally in the cycle it asserts pop, so the entry must remain stable until the pop edge.

Optional Feature:
- Macro: ALU_BUFFER_PERF_EN.
- When defined, the block adds:
  - output alu_buffer_stall_cnt [31:0]: increments at each edge where alu_dispat_push & alu_buffer_full & ~flush. It saturates at 32'hFFFFFFFF, resets to 0 on RST, and is not cleared by flush.
  - output alu_buffer_hiwater [$clog2(DP):0]: maximum cnt seen since reset.
- When not defined, neither port exists and no perf logic is synthesised.

Test Plan (DP=4):
- Reset then idle:
  - Assert RST mid-cycle -> malloc=4'b0000, cnt=0, full=0 with no clock edge; info all zero.
- Fill:
  - Push A,B,C,D on consecutive cycles, no pops -> malloc=0001,0011,0111,1111; info[0..3]=A..D; cnt=4; full=1.
  - A fifth push E leaves state unchanged.
- Hole refill:
  - From full, pop index 2 -> malloc=1011, cnt=3.
  - Next cycle push E -> E lands in entry 2, malloc=1111.
- Simultaneous push and pop at full:
  - malloc=1111; push F with pop index 0 -> malloc=1110, F refused, cnt=3.
  - Retried push next cycle -> F in entry 0.
- Simultaneous push and pop, not full:
  - malloc=0011; push G with pop index 0 -> G goes to entry 2, malloc=0110, cnt unchanged at 2.
- Flush:
  - malloc=0111; flush with push H and pop index 1 -> malloc=0000, cnt=0, H dropped.
  - Next push lands in entry 0.
  - With ALU_BUFFER_PERF_EN, 3 refused pushes while full -> stall_cnt=3 and hiwater=4.
